wb_stream_loader: RTL

Wishbone master that loads a byte stream into a 32-bit Wishbone block RAM, such as a boot/program image arriving from a UART or debug link. Bytes are packed little-endian into words, and each word is written with a byte-lane select. Partial final words get a partial select. The block reports word count, completion and bus-timeout error. It sits directly upstream of the BlockRAM slave on its Wishbone port.

---
 rtl/wb_stream_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/wb_stream_loader.sv
// rtl/wb_stream_loader.sv - Wishbone master packing a byte stream into 32-bit RAM words
module wb_stream_loader #(
  parameter int ADR_WIDTH   = 11,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] base_adr_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] word_cnt_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  // Address bits at or above ADR_WIDTH are frozen from base_adr_i.
  localparam logic [31:0] ADR_MASK = (ADR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'h1 << ADR_WIDTH) - 32'h1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [3:0]     sel_q, sel_d;
  logic [1:0]     idx_q, idx_d;
  logic           last_q, last_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           rdy_q, rdy_d;
  logic           stb_q, stb_d;
  logic           busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    rdy_d   = rdy_q;
    stb_d   = stb_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          adr_d   = base_adr_i & ~32'h3;
          dat_d   = 32'h0;
          sel_d   = 4'h0;
          idx_d   = 2'd0;
          last_d  = 1'b0;
          cnt_d   = 16'h0;
          err_d   = 1'b0;
          rdy_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (s_valid_i && rdy_q) begin
          dat_d[{idx_q, 3'b000} +: 8] = s_data_i;
          sel_d[idx_q] = 1'b1;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3 || s_last_i) begin
            last_d  = s_last_i;
            rdy_d   = 1'b0;
            stb_d   = 1'b1;
            tmo_d   = '0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (wb_ack_i) begin
          stb_d = 1'b0;
          adr_d = (adr_q & ~ADR_MASK) | ((adr_q + 32'd4) & ADR_MASK);
          cnt_d = cnt_q + 16'd1;
          dat_d = 32'h0;
          sel_d = 4'h0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            rdy_d   = 1'b1;
            state_d = S_COLLECT;
          end
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          // Abort: the unanswered word and any remaining stream bytes are abandoned.
          stb_d   = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      sel_q   <= 4'h0;
      idx_q   <= 2'd0;
      last_q  <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= 16'h0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

  assign s_ready_o  = rdy_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign word_cnt_o = cnt_q;
  assign wb_cyc_o   = stb_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = stb_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;

endmodule
